mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store unit between a pipeline and a byte-addressed data memory of
// MEM_SIZE bytes. Aligned requests are performed as a single memory access of
// the requested size. Misaligned requests are broken into one single-byte
// access per cycle. Requests with an illegal size, or that reach past the end
// of memory, are answered with an error and never touch memory.
//
// Ports
//   clk               clock, rising edge
//   reset_n           asynchronous active-low reset
//   req_valid/ready   request handshake
//   req_write         1 = store, 0 = load
//   req_addr          byte address
//   req_size          transfer bytes (1, 2, 4, 8)
//   req_signed        sign-extend load data when 1
//   req_wdata         store data, little-endian, low req_size bytes used
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_error        request rejected
//   mem_address       memory byte address
//   mem_write_enable  memory write strobe
//   mem_read_enable   memory read strobe
//   mem_write_data    memory write data
//   mem_xfer_size     memory transfer size in bytes
//   mem_read_data     memory read data (combinational from the memory)
//   dbg_state         current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only while the unit is idle, and the
// request fields are ignored whenever req_ready is 0. There is no response
// backpressure: resp_valid is high for exactly one cycle per request.
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int unsigned MEM_SIZE = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [3:0]  req_size,
   input  logic        req_signed,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_error,
   output logic [63:0] mem_address,
   output logic        mem_write_enable,
   output logic        mem_read_enable,
   output logic [63:0] mem_write_data,
   output logic [3:0]  mem_xfer_size,
   input  logic [63:0] mem_read_data,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_SPLIT  = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   localparam logic [63:0] MEM_SIZE_64 = 64'(MEM_SIZE);

   state_t      r_state;
   state_t      w_next_state;

   logic        r_write;
   logic [63:0] r_addr;
   logic [3:0]  r_size;
   logic        r_signed;
   logic [63:0] r_wdata;
   logic [63:0] r_buf;
   logic [2:0]  r_k;
   logic        r_error;

   logic        w_accept;
   logic        w_size_ok;
   logic [63:0] w_size_64;
   logic        w_oob;
   logic        w_misaligned;
   logic        w_reject;
   logic        w_last_byte;

   // ---------------------------------------------------------------------------
   // Request classification (evaluated on the live request inputs)
   // ---------------------------------------------------------------------------
   assign w_accept  = req_valid && (r_state == S_IDLE);
   assign w_size_ok = (req_size == 4'd1) || (req_size == 4'd2) ||
                      (req_size == 4'd4) || (req_size == 4'd8);
   assign w_size_64 = {60'd0, req_size};

   // Compare against MEM_SIZE-size rather than computing addr+size, so a
   // huge address cannot wrap around and appear to be in range.
   assign w_oob = (MEM_SIZE_64 < w_size_64) ||
                  (req_addr > (MEM_SIZE_64 - w_size_64));

   // For legal sizes, size-1 in three bits is the alignment mask
   // (size 8 wraps 0-1 to 7; size 1 gives an empty mask).
   assign w_misaligned = |(req_addr[2:0] & (req_size[2:0] - 3'd1));
   assign w_reject     = !w_size_ok || w_oob;

   // The split loop ends after byte size-1; for size 8 this is 3'd7.
   assign w_last_byte = (r_k == (r_size[2:0] - 3'd1));

   // ---------------------------------------------------------------------------
   // Load data extension
   // ---------------------------------------------------------------------------
   function automatic logic [63:0] extend_load(input logic [63:0] d,
                                               input logic [3:0]  sz,
                                               input logic        sgn);
      logic [63:0] v;
      v = d;
      case (sz)
         4'd1:    v = sgn ? {{56{d[7]}},  d[7:0]}  : {56'd0, d[7:0]};
         4'd2:    v = sgn ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
         4'd4:    v = sgn ? {{32{d[31]}}, d[31:0]} : {32'd0, d[31:0]};
         default: v = d;
      endcase
      return v;
   endfunction

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state and outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      w_next_state     = r_state;
      req_ready        = 1'b0;
      resp_valid       = 1'b0;
      resp_rdata       = 64'd0;
      resp_error       = 1'b0;
      mem_address      = 64'd0;
      mem_write_enable = 1'b0;
      mem_read_enable  = 1'b0;
      mem_write_data   = 64'd0;
      mem_xfer_size    = 4'd8;

      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_reject) begin
                  w_next_state = S_RESP;
               end else if (w_misaligned) begin
                  w_next_state = S_SPLIT;
               end else begin
                  w_next_state = S_ACCESS;
               end
            end
         end

         S_ACCESS: begin
            mem_address      = r_addr;
            mem_xfer_size    = r_size;
            mem_write_enable = r_write;
            mem_read_enable  = !r_write;
            mem_write_data   = r_write ? r_wdata : 64'd0;
            w_next_state     = S_RESP;
         end

         S_SPLIT: begin
            mem_address      = r_addr + {61'd0, r_k};
            mem_xfer_size    = 4'd1;
            mem_write_enable = r_write;
            mem_read_enable  = !r_write;
            mem_write_data   = r_write ? {56'd0, r_wdata[{r_k, 3'b000} +: 8]} : 64'd0;
            if (w_last_byte) begin
               w_next_state = S_RESP;
            end
         end

         S_RESP: begin
            resp_valid   = 1'b1;
            resp_error   = r_error;
            if (!r_error && !r_write) begin
               resp_rdata = extend_load(r_buf, r_size, r_signed);
            end
            w_next_state = S_IDLE;
         end

         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Request latch, byte counter and load buffer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_write  <= 1'b0;
         r_addr   <= 64'd0;
         r_size   <= 4'd0;
         r_signed <= 1'b0;
         r_wdata  <= 64'd0;
         r_buf    <= 64'd0;
         r_k      <= 3'd0;
         r_error  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_write  <= req_write;
                  r_addr   <= req_addr;
                  r_size   <= req_size;
                  r_signed <= req_signed;
                  r_wdata  <= req_wdata;
                  r_buf    <= 64'd0;
                  r_k      <= 3'd0;
                  r_error  <= w_reject;
               end
            end

            S_ACCESS: begin
               if (!r_write) begin
                  r_buf <= mem_read_data;
               end
            end

            S_SPLIT: begin
               if (!r_write) begin
                  r_buf[{r_k, 3'b000} +: 8] <= mem_read_data[7:0];
               end
               r_k <= r_k + 3'd1;
            end

            default: begin
            end
         endcase
      end
   end

   assign dbg_state = r_state;

endmodule
